// File: rtl/common_types_pkg.sv
// Shared types for the memory stage: FSM states, PC-control and writeback-source
// encodings, and the store-size codes carried on ex_dwrite.
package common_types_pkg;

  typedef enum logic {IDLE, BUSY} mem_state_t;

  typedef enum logic [1:0] {
    PC_INC    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JAL    = 2'd2,
    PC_JALR   = 2'd3
  } pc_ctrl_t;

  typedef enum logic [1:0] {
    WR_ALU  = 2'd0,
    WR_MEM  = 2'd1,
    WR_PC4  = 2'd2,
    WR_ZERO = 2'd3
  } wr_src_t;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

endpackage

// File: rtl/store_align.sv
// Byte-lane strobe and replicated write-data formation for data-memory stores.
module store_align
  import common_types_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  strb,
  output logic [31:0] wdata
);

  always_comb begin
    strb  = 4'b0000;
    wdata = data;
    case (size)
      SZ_BYTE: begin
        strb  = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{data[15:0]}};
      end
      SZ_WORD: strb = 4'b1111;
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: dmem handshake FSM with timeout, branch/jump redirect, MEM/WB drive.
// Optional misaligned-access trap is built when MEM_MISALIGN_TRAP_EN is defined.
//
//  state | meaning
//  IDLE  | no transaction outstanding; a new access requests combinationally
//  BUSY  | request outstanding, waiting on dmem_ready or timeout
module memory_stage
  import common_types_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_halt,
  input  logic [4:0]  ex_rd,
  input  logic        ex_dread,
  input  logic [1:0]  ex_dwrite,
  input  logic [1:0]  ex_reg_wr_src,
  input  logic        ex_branch_pol,
  input  logic [1:0]  ex_pc_ctrl,
  input  logic [31:0] ex_rdat2,
  input  logic [31:0] ex_alu_out,
  input  logic        ex_alu_zero,
  input  logic [31:0] ex_pc_plus_imm,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        mem_stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        wb_valid,
  output logic        wb_halt,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_reg_wr_src,
  output logic [31:0] wb_data,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             bus_err_q;
  logic             halted;
  logic             is_store, mem_access, misalign, issue, timeout, req;
  logic [1:0]       size;
  logic [3:0]       strb;
  logic [31:0]      wdata;
  logic             take;
  logic [31:0]      target;

  assign is_store   = (ex_dwrite != SZ_NONE);
  assign size       = is_store ? ex_dwrite : SZ_WORD;
  assign mem_access = ~rst & ex_valid & (ex_dread | is_store) & ~halted;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_access &
                    (((size == SZ_HALF) & ex_alu_out[0]) |
                     ((size == SZ_WORD) & (ex_alu_out[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign issue   = mem_access & ~misalign;
  assign timeout = (state == BUSY) & (cnt == CNT_W'(TIMEOUT_CYCLES));
  // Request is live from the first cycle of an access, so zero-wait completes without a bubble.
  assign req     = ~rst & ((state == IDLE) ? issue : ~timeout);

  assign mem_stall = req & ~dmem_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (issue & ~dmem_ready) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        if (dmem_ready | timeout) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_err_q <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (timeout | misalign) bus_err_q <= 1'b1;
      if (wb_halt) halted <= 1'b1;
    end
  end

  store_align u_store_align (
    .size    (size),
    .addr_lo (ex_alu_out[1:0]),
    .data    (ex_rdat2),
    .strb    (strb),
    .wdata   (wdata)
  );

  assign dmem_req   = req;
  assign dmem_we    = req & is_store;
  assign dmem_strb  = dmem_we ? strb : 4'b0000;
  assign dmem_addr  = req ? {ex_alu_out[31:2], 2'b00} : 32'h0;
  assign dmem_wdata = dmem_we ? wdata : 32'h0;

  always_comb begin
    take   = 1'b0;
    target = ex_pc_plus_imm;
    case (pc_ctrl_t'(ex_pc_ctrl))
      PC_BRANCH: take = ex_alu_zero ^ ex_branch_pol;
      PC_JAL:    take = 1'b1;
      PC_JALR: begin
        take   = 1'b1;
        target = {ex_alu_out[31:1], 1'b0};
      end
      default: ;
    endcase
  end

  assign redirect    = ~rst & ex_valid & ~mem_stall & take;
  assign redirect_pc = redirect ? target : RESET_PC;

  assign wb_valid      = ~rst & ex_valid & ~mem_stall;
  assign wb_halt       = wb_valid & ex_halt;
  // A trapped misaligned access still retires, but must not write a register.
  assign wb_rd         = (wb_valid & ~misalign) ? ex_rd : 5'd0;
  assign wb_reg_wr_src = wb_valid ? ex_reg_wr_src : 2'd0;

  always_comb begin
    wb_data = 32'h0;
    if (wb_valid) begin
      case (wr_src_t'(ex_reg_wr_src))
        WR_ALU:  wb_data = ex_alu_out;
        WR_MEM:  wb_data = dmem_rdata;
        WR_PC4:  wb_data = ex_pc + 32'd4;
        default: wb_data = 32'h0;
      endcase
    end
  end

  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: vector table for single-cycle behaviour,
// hand sequences for wait states, timeout, reset-in-flight and halt; retirements via scoreboard.
module tb_memory_stage;

  localparam int          TO  = 8;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_halt, ex_dread, ex_branch_pol, ex_alu_zero;
  logic [31:0] ex_pc, ex_rdat2, ex_alu_out, ex_pc_plus_imm;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_dwrite, ex_reg_wr_src, ex_pc_ctrl;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [3:0]  dmem_strb;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        mem_stall, redirect, wb_valid, wb_halt, bus_err;
  logic [31:0] redirect_pc, wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_reg_wr_src;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT_CYCLES(TO), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_halt(ex_halt), .ex_rd(ex_rd),
    .ex_dread(ex_dread), .ex_dwrite(ex_dwrite), .ex_reg_wr_src(ex_reg_wr_src),
    .ex_branch_pol(ex_branch_pol), .ex_pc_ctrl(ex_pc_ctrl), .ex_rdat2(ex_rdat2),
    .ex_alu_out(ex_alu_out), .ex_alu_zero(ex_alu_zero), .ex_pc_plus_imm(ex_pc_plus_imm),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_strb(dmem_strb), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_stall(mem_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .wb_valid(wb_valid), .wb_halt(wb_halt), .wb_rd(wb_rd), .wb_reg_wr_src(wb_reg_wr_src),
    .wb_data(wb_data), .bus_err(bus_err)
  );

  typedef struct {
    string       name;
    logic        dr;
    logic [1:0]  dw, pcc, src;
    logic        pol, zero;
    logic [31:0] pc, alu, ppi, rdat2, rdata;
    logic        ereq, ewe;
    logic [3:0]  estrb;
    logic [31:0] ewdata, eaddr;
    logic        eredir;
    logic [31:0] erpc, ewb;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        halt;
  } wb_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  wb_t  sb[$];
  wb_t  exp_wb;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic dr, input logic [1:0] dw,
                              input logic [1:0] pcc, input logic pol, input logic zero,
                              input logic [1:0] src, input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] ppi, input logic [31:0] rdat2,
                              input logic [31:0] rdata, input logic ereq, input logic ewe,
                              input logic [3:0] estrb, input logic [31:0] ewdata,
                              input logic [31:0] eaddr, input logic eredir,
                              input logic [31:0] erpc, input logic [31:0] ewb);
    vec_t v;
    v.name = nm; v.dr = dr; v.dw = dw; v.pcc = pcc; v.pol = pol; v.zero = zero; v.src = src;
    v.pc = pc; v.alu = alu; v.ppi = ppi; v.rdat2 = rdat2; v.rdata = rdata;
    v.ereq = ereq; v.ewe = ewe; v.estrb = estrb; v.ewdata = ewdata; v.eaddr = eaddr;
    v.eredir = eredir; v.erpc = erpc; v.ewb = ewb;
    return v;
  endfunction

  task automatic idle_in();
    ex_valid = 0; ex_halt = 0; ex_dread = 0; ex_dwrite = 0; ex_reg_wr_src = 0;
    ex_branch_pol = 0; ex_pc_ctrl = 0; ex_alu_zero = 0; ex_rd = 0;
    ex_pc = 0; ex_rdat2 = 0; ex_alu_out = 0; ex_pc_plus_imm = 0;
    dmem_ready = 0; dmem_rdata = 0;
  endtask

  // Every retirement must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_retire: got rd=%0d data=%h, expected no retirement", wb_rd, wb_data);
      end else begin
        exp_wb = sb.pop_front();
        chk("wb.data", wb_data, exp_wb.data);
        chk("wb.rd", 32'(wb_rd), 32'(exp_wb.rd));
        chk("wb.halt", 32'(wb_halt), 32'(exp_wb.halt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    int   stalls;
    logic done;
    vec_t v;

    //          name        dr dw pcc pol z src pc            alu           ppi           rdat2         rdata         req we strb     wdata         addr          rd rpc           wb
    vecs.push_back(mk("sb_1003",  0, 1, 0, 0, 0, 0, 32'h0,        32'h1003,     32'h0,     32'hAB,       32'h0,        1, 1, 4'b1000, 32'hABABABAB, 32'h1000, 0, RPC,     32'h1003));
    vecs.push_back(mk("sb_1001",  0, 1, 0, 0, 0, 0, 32'h0,        32'h1001,     32'h0,     32'h1234565A, 32'h0,        1, 1, 4'b0010, 32'h5A5A5A5A, 32'h1000, 0, RPC,     32'h1001));
    vecs.push_back(mk("sh_2002",  0, 2, 0, 0, 0, 0, 32'h0,        32'h2002,     32'h0,     32'h1234CDEF, 32'h0,        1, 1, 4'b1100, 32'hCDEFCDEF, 32'h2000, 0, RPC,     32'h2002));
    vecs.push_back(mk("sh_2000",  0, 2, 0, 0, 0, 0, 32'h0,        32'h2000,     32'h0,     32'h1234CDEF, 32'h0,        1, 1, 4'b0011, 32'hCDEFCDEF, 32'h2000, 0, RPC,     32'h2000));
    vecs.push_back(mk("sw_3000",  0, 3, 0, 0, 0, 0, 32'h0,        32'h3000,     32'h0,     32'hDEADBEEF, 32'h0,        1, 1, 4'b1111, 32'hDEADBEEF, 32'h3000, 0, RPC,     32'h3000));
    vecs.push_back(mk("lw_0400",  1, 0, 0, 0, 0, 1, 32'h0,        32'h400,      32'h0,     32'h0,        32'hCAFEF00D, 1, 0, 4'b0000, 32'h0,        32'h400,  0, RPC,     32'hCAFEF00D));
    vecs.push_back(mk("lw_0403",  1, 0, 0, 0, 0, 1, 32'h0,        32'h403,      32'h0,     32'h0,        32'h01020304, 1, 0, 4'b0000, 32'h0,        32'h400,  0, RPC,     32'h01020304));
    vecs.push_back(mk("ld_st",    1, 3, 0, 0, 0, 0, 32'h0,        32'h3004,     32'h0,     32'h55AA55AA, 32'h0,        1, 1, 4'b1111, 32'h55AA55AA, 32'h3004, 0, RPC,     32'h3004));
    vecs.push_back(mk("beq_tk",   0, 0, 1, 0, 1, 0, 32'h0,        32'h0,        32'h40,    32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    1, 32'h40,  32'h0));
    vecs.push_back(mk("bne_nt",   0, 0, 1, 1, 1, 0, 32'h0,        32'h0,        32'h40,    32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    0, RPC,     32'h0));
    vecs.push_back(mk("bne_tk",   0, 0, 1, 1, 0, 0, 32'h0,        32'h5,        32'h44,    32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    1, 32'h44,  32'h5));
    vecs.push_back(mk("beq_nt",   0, 0, 1, 0, 0, 0, 32'h0,        32'h7,        32'h48,    32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    0, RPC,     32'h7));
    vecs.push_back(mk("jal",      0, 0, 2, 0, 0, 2, 32'h10,       32'h0,        32'h80,    32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    1, 32'h80,  32'h14));
    vecs.push_back(mk("jalr",     0, 0, 3, 0, 0, 2, 32'h20,       32'h101,      32'h999,   32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    1, 32'h100, 32'h24));
    vecs.push_back(mk("src3",     0, 0, 0, 0, 0, 3, 32'h0,        32'h1234,     32'h0,     32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    0, RPC,     32'h0));
    vecs.push_back(mk("pc4_wrap", 0, 0, 0, 0, 0, 2, 32'hFFFFFFFC, 32'h0,        32'h500,   32'h0,        32'h0,        0, 0, 4'b0000, 32'h0,        32'h0,    0, RPC,     32'h0));

    idle_in();
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.req", 32'(dmem_req), 0);
    chk("rst.stall", 32'(mem_stall), 0);
    chk("rst.redirect", 32'(redirect), 0);
    chk("rst.redirect_pc", redirect_pc, RPC);
    chk("rst.wb_valid", 32'(wb_valid), 0);
    chk("rst.bus_err", 32'(bus_err), 0);
    @(posedge clk); #1;
    rst = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      idle_in();
      ex_valid = 1; ex_dread = v.dr; ex_dwrite = v.dw; ex_pc_ctrl = v.pcc;
      ex_branch_pol = v.pol; ex_alu_zero = v.zero; ex_reg_wr_src = v.src; ex_pc = v.pc;
      ex_alu_out = v.alu; ex_pc_plus_imm = v.ppi; ex_rdat2 = v.rdat2; ex_rd = 5'(i + 1);
      dmem_ready = 1; dmem_rdata = v.rdata;
      sb.push_back('{rd: 5'(i + 1), data: v.ewb, halt: 1'b0});
      @(negedge clk);
      chk({v.name, ".req"}, 32'(dmem_req), 32'(v.ereq));
      chk({v.name, ".we"}, 32'(dmem_we), 32'(v.ewe));
      chk({v.name, ".strb"}, 32'(dmem_strb), 32'(v.estrb));
      chk({v.name, ".wdata"}, dmem_wdata, v.ewdata);
      chk({v.name, ".addr"}, dmem_addr, v.eaddr);
      chk({v.name, ".stall"}, 32'(mem_stall), 0);
      chk({v.name, ".redirect"}, 32'(redirect), 32'(v.eredir));
      chk({v.name, ".redirect_pc"}, redirect_pc, v.erpc);
    end

    // Word load answered after three wait cycles.
    @(posedge clk); #1;
    idle_in();
    ex_valid = 1; ex_dread = 1; ex_reg_wr_src = 1; ex_alu_out = 32'h500; ex_rd = 7;
    ex_pc_ctrl = 1; ex_alu_zero = 1; ex_pc_plus_imm = 32'h60;
    sb.push_back('{rd: 5'd7, data: 32'h11223344, halt: 1'b0});
    stalls = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      chk("late.req_held", 32'(dmem_req), 1);
      chk("late.addr", dmem_addr, 32'h500);
      chk("late.no_redirect", 32'(redirect), 0);
      @(posedge clk); #1;
    end
    dmem_ready = 1; dmem_rdata = 32'h11223344;
    @(negedge clk);
    chk("late.stall_cycles", stalls, 3);
    chk("late.stall_end", 32'(mem_stall), 0);
    chk("late.redirect", 32'(redirect), 1);
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    chk("late.req_done", 32'(dmem_req), 0);

    // No response: timeout after TO busy cycles.
    @(posedge clk); #1;
    idle_in();
    ex_valid = 1; ex_dread = 1; ex_reg_wr_src = 1; ex_alu_out = 32'h600; ex_rd = 9;
    sb.push_back('{rd: 5'd9, data: 32'h0, halt: 1'b0});
    stalls = 0; done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) stalls++;
      else done = 1;
    end
    chk("to.completed", 32'(done), 1);
    chk("to.stall_cycles", stalls, TO + 1);
    chk("to.req_dropped", 32'(dmem_req), 0);
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    chk("to.bus_err", 32'(bus_err), 1);
    chk("to.idle_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    ex_valid = 1; ex_dwrite = 3; ex_alu_out = 32'h604; ex_rd = 10; dmem_ready = 1;
    sb.push_back('{rd: 5'd10, data: 32'h604, halt: 1'b0});
    @(negedge clk);
    chk("to.next_req", 32'(dmem_req), 1);
    chk("to.next_stall", 32'(mem_stall), 0);
    chk("to.bus_err_sticky", 32'(bus_err), 1);

    // Reset while a load is outstanding; the late response must be ignored.
    @(posedge clk); #1;
    idle_in();
    ex_valid = 1; ex_dread = 1; ex_reg_wr_src = 1; ex_alu_out = 32'h700; ex_rd = 11;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstbusy.req_before", 32'(dmem_req), 1);
    @(posedge clk); #1;
    rst = 1; ex_valid = 0; ex_dread = 0;
    @(negedge clk);
    chk("rstbusy.req", 32'(dmem_req), 0);
    chk("rstbusy.stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    rst = 0; dmem_ready = 1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rstbusy.late_req", 32'(dmem_req), 0);
    chk("rstbusy.late_wb", 32'(wb_valid), 0);
    chk("rstbusy.bus_err", 32'(bus_err), 0);

    // Halt retires, then memory requests are blocked until reset.
    @(posedge clk); #1;
    idle_in();
    ex_valid = 1; ex_halt = 1; ex_alu_out = 32'h77; ex_rd = 3;
    sb.push_back('{rd: 5'd3, data: 32'h77, halt: 1'b1});
    @(posedge clk); #1;
    idle_in();
    ex_valid = 1; ex_dwrite = 3; ex_alu_out = 32'h800; ex_rd = 4; dmem_ready = 1;
    sb.push_back('{rd: 5'd4, data: 32'h800, halt: 1'b0});
    @(negedge clk);
    chk("halt.req_blocked", 32'(dmem_req), 0);
    chk("halt.stall", 32'(mem_stall), 0);
    @(posedge clk); #1;
    idle_in();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    ex_valid = 1; ex_dwrite = 3; ex_alu_out = 32'h804; ex_rd = 5; dmem_ready = 1;
    sb.push_back('{rd: 5'd5, data: 32'h804, halt: 1'b0});
    @(negedge clk);
    chk("halt.req_after_rst", 32'(dmem_req), 1);
    @(posedge clk); #1;
    idle_in();
    repeat (2) @(negedge clk);

    chk("sb.drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
